// File: rtl/nn_mlp_pkg.sv
// Shared types and Q-format helpers for the MLP inference engine.
// Activations and weights are signed fixed point with FRAC fractional bits.
package nn_mlp_pkg;

  typedef enum logic [2:0] {IDLE, MAC, BIAS, WRITE, ARGMAX, DONE} state_t;

  localparam int Q_W = 16;
  localparam int Q_ONE_SHIFT = 15;
  localparam logic signed [Q_W-1:0] ACT_MAX = 16'sh7FFF;

  // Unsigned 8-bit pixel placed just below the sign bit of a dw-bit word.
  function automatic logic [63:0] px_to_q15(input logic [7:0] px, input int dw);
    return 64'(px) << (dw - 9);
  endfunction

  // relu=1 clamps to [0, max]; relu=0 clamps symmetrically to [-max, max].
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input logic relu, input int dw);
    logic signed [63:0] hi, lo;
    hi = (dw == Q_W) ? 64'(ACT_MAX) : ((64'sd1 <<< (dw - 1)) - 64'sd1);
    lo = relu ? 64'sd0 : -hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One neuron lane: wrapping multiply-accumulate, bias add and
// rescale/saturate of the accumulator into an activation word.
module nn_mac_lane
  import nn_mlp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int FRAC   = Q_ONE_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     mac_en,
  input  logic                     bias_en,
  input  logic                     relu,
  input  logic signed [DATA_W-1:0] src,
  input  logic signed [DATA_W-1:0] w,
  output logic signed [DATA_W-1:0] act
);

  logic signed [ACC_W-1:0]    acc_reg, acc_next;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    shifted;

  assign prod = src * w;

  always_comb begin
    acc_next = acc_reg;
    if (clr)
      acc_next = '0;
    else if (mac_en)
      acc_next = acc_reg + ACC_W'(prod);
    else if (bias_en)
      acc_next = acc_reg + (ACC_W'(w) <<< FRAC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_reg <= '0;
    else
      acc_reg <= acc_next;
  end

  assign shifted = acc_reg >>> FRAC;
  assign act     = DATA_W'(sat_relu(64'(shifted), relu, DATA_W));

endmodule

// File: rtl/nn_mlp_engine.sv
// Self-sequencing MLP inference: N_NODES parallel lanes walk every layer,
// then a sequential argmax over the logits produces class_idx.
module nn_mlp_engine
  import nn_mlp_pkg::*;
#(
  parameter int N_NODES   = 15,
  parameter int IN_LEN    = 256,
  parameter int N_LAYERS  = 3,
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int FRAC      = Q_ONE_SHIFT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(IN_LEN)-1:0]     img_addr,
  input  logic [7:0]                    img_byte,
  output logic [$clog2(N_LAYERS)-1:0]   w_layer,
  output logic [$clog2(IN_LEN+1)-1:0]   w_addr,
  input  logic [N_NODES*DATA_W-1:0]     w_data,
  output logic [$clog2(N_CLASSES)-1:0]  class_idx
);

  localparam int IAW = $clog2(IN_LEN);
  localparam int WAW = $clog2(IN_LEN + 1);
  localparam int LW  = $clog2(N_LAYERS);
  localparam int CW  = $clog2(N_CLASSES);
  localparam int NW  = $clog2(N_NODES);

  state_t                    state_reg, state_next;
  logic [WAW-1:0]            k_reg, k_next, fan_last;
  logic [LW-1:0]             layer_reg, layer_next;
  logic [CW-1:0]             ai_reg, ai_next, best_idx_reg, best_idx_next, class_reg, class_next;
  logic signed [DATA_W-1:0]  best_val_reg, best_val_next, src, logit;
  logic signed [DATA_W-1:0]  act_buf  [N_NODES];
  logic signed [DATA_W-1:0]  lane_act [N_NODES];
  logic                      last_layer, accept, lane_clr, greater;

  assign last_layer = (layer_reg == LW'(N_LAYERS - 1));
  assign accept     = start && (state_reg == IDLE || state_reg == DONE);
  assign lane_clr   = accept || (state_reg == WRITE);
  assign fan_last   = (layer_reg == '0) ? WAW'(IN_LEN - 1) : WAW'(N_NODES - 1);
  assign src        = (layer_reg == '0) ? DATA_W'(px_to_q15(img_byte, DATA_W))
                                        : act_buf[NW'(k_reg)];
  assign logit      = act_buf[NW'(ai_reg)];
  // Strict compare keeps the lowest index on ties.
  assign greater    = (ai_reg == '0) || (logit > best_val_reg);

  generate
    for (genvar gi = 0; gi < N_NODES; gi++) begin : g_lane
      nn_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC(FRAC)) u_lane (
        .clk     (clk),
        .reset   (reset),
        .clr     (lane_clr),
        .mac_en  (state_reg == MAC),
        .bias_en (state_reg == BIAS),
        .relu    (!last_layer),
        .src     (src),
        .w       (w_data[gi*DATA_W +: DATA_W]),
        .act     (lane_act[gi])
      );

      // Logits of the last layer reuse the activation buffer.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          act_buf[gi] <= '0;
        else if (state_reg == WRITE)
          act_buf[gi] <= lane_act[gi];
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    layer_next    = layer_reg;
    ai_next       = ai_reg;
    best_val_next = best_val_reg;
    best_idx_next = best_idx_reg;
    class_next    = class_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          state_next = MAC;
          k_next     = '0;
          layer_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      MAC: begin
        // k lands on the bias row when the fan-in is exhausted.
        k_next = k_reg + WAW'(1);
        if (k_reg == fan_last)
          state_next = BIAS;
      end
      BIAS:  state_next = WRITE;
      WRITE: begin
        k_next     = '0;
        layer_next = layer_reg + LW'(1);
        ai_next    = '0;
        state_next = last_layer ? ARGMAX : MAC;
      end
      ARGMAX: begin
        if (greater) begin
          best_val_next = logit;
          best_idx_next = ai_reg;
        end
        ai_next = ai_reg + CW'(1);
        if (ai_reg == CW'(N_CLASSES - 1)) begin
          class_next = greater ? ai_reg : best_idx_reg;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      layer_reg    <= '0;
      ai_reg       <= '0;
      best_val_reg <= '0;
      best_idx_reg <= '0;
      class_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      layer_reg    <= layer_next;
      ai_reg       <= ai_next;
      best_val_reg <= best_val_next;
      best_idx_reg <= best_idx_next;
      class_reg    <= class_next;
    end
  end

  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);
  assign img_addr  = k_reg[IAW-1:0];
  assign w_addr    = k_reg;
  assign w_layer   = layer_reg;
  assign class_idx = class_reg;

endmodule
